// File: rtl/data_mem_pkg.sv
// Shared types and width helpers for the burst data memory.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    // Beat-count field width; never narrower than one bit.
    function automatic int len_w(input int max_burst);
        if (max_burst <= 2) return 1;
        return $clog2(max_burst);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port RAM with synchronous write and an RD_LAT-deep registered read path
// carrying valid/last sidebands; the read path is cleared by rst_n, the RAM is not.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              re_last,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [DATA_W-1:0] pipe_data  [RD_LAT];
    logic              pipe_valid [RD_LAT];
    logic              pipe_last  [RD_LAT];

    // A reset in the same cycle as a write strobe suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data[i]  <= '0;
                pipe_valid[i] <= 1'b0;
                pipe_last[i]  <= 1'b0;
            end
        end else begin
            pipe_data[0]  <= mem[addr];
            pipe_valid[0] <= re;
            pipe_last[0]  <= re && re_last;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_data[i]  <= pipe_data[i-1];
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end
        end
    end

    assign rd_valid = pipe_valid[RD_LAT-1];
    assign rd_data  = pipe_data[RD_LAT-1];
    assign rd_last  = pipe_last[RD_LAT-1];

endmodule

// File: rtl/data_mem_burst.sv
// Burst front end for the data memory: accepts one request, then sequences
// 1..MAX_BURST consecutive write or read beats through the RAM array.
//
//   state | meaning
//   IDLE  | ready for a request (req_ready=1)
//   WR    | accepting write beats, one per wr_valid
//   RD    | issuing one read per cycle, no stalls
//   DRAIN | waiting for the last read beat to leave the pipeline
module data_mem_burst
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = len_w(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic              mem_we;
    logic              rd_en;

    assign mem_we = (state == WR) && wr_valid && wr_ready;
    assign rd_en  = (state == RD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            req_ready <= 1'b0;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        addr      <= req_addr;
                        count     <= req_len;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_write) begin
                            state    <= WR;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    if (wr_valid && wr_ready) begin
                        addr  <= addr + ADDR_W'(1);
                        count <= count - LEN_W'(1);
                        if (count == '0) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                RD: begin
                    addr  <= addr + ADDR_W'(1);
                    count <= count - LEN_W'(1);
                    if (count == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The tagged last beat at the output means nothing is left in flight.
                    if (rd_valid && rd_last) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (mem_we),
        .addr     (addr),
        .wdata    (wr_data),
        .re       (rd_en),
        .re_last  (count == '0),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last)
    );

endmodule

// File: tb/tb_data_mem_burst.sv
// Randomised scoreboard bench for data_mem_burst with RD_LAT=2: a reference memory
// array predicts every read beat (data, last flag and arrival cycle).
module tb_data_mem_burst;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = 4;
    localparam int DEPTH     = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;

    data_mem_burst #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         cyc;
    } beat_t;

    beat_t      sb[$];
    logic [7:0] ref_mem [DEPTH];
    int         n_checks = 0;
    int         n_pass = 0;
    int         beats_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every presented read beat must match the oldest predicted beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_rd_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", rd_data, e.data);
                    check("rd_last", rd_last, e.last);
                    check("rd_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Holds the request until accepted; hs is the handshake cycle (-1 on timeout).
    task automatic request(input bit wr, input int a, input int len, output int hs);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = 8'(a);
        req_len   = 4'(len);
        hs = -1;
        for (int t = 0; t < 200; t++) begin
            if (req_ready === 1'b1) begin
                hs = cyc;
                break;
            end
            tick();
        end
        if (hs < 0) check("req_accept_timeout", 0, 1);
        else tick();
        req_valid = 1'b0;
    endtask

    task automatic read_burst(input int a, input int len, output int hs);
        beat_t e;
        request(1'b0, a, len, hs);
        if (hs >= 0) begin
            for (int i = 0; i <= len; i++) begin
                e.data = ref_mem[(a + i) % DEPTH];
                e.last = (i == len);
                e.cyc  = hs + 1 + RD_LAT + i;
                sb.push_back(e);
            end
        end
    endtask

    task automatic write_burst(input int a, input int len, input logic [15:0] stall,
                               input bit rnd, input int base);
        int         hs;
        int         t;
        logic [7:0] d;
        request(1'b1, a, len, hs);
        for (int i = 0; i <= len; i++) begin
            d = rnd ? 8'($urandom) : 8'(base + i);
            if (stall[i]) begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
                tick();
            end
            wr_valid = 1'b1;
            wr_data  = d;
            t = 0;
            while (wr_ready !== 1'b1 && t < 50) begin
                tick();
                t++;
            end
            if (wr_ready !== 1'b1) check("wr_ready_timeout", 0, 1);
            tick();
            ref_mem[(a + i) % DEPTH] = d;
        end
        wr_valid = 1'b0;
        check("wr_ready_after_burst", wr_ready, 0);
        check("busy_after_write", busy, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && t < 200) begin
            tick();
            t++;
        end
        check("idle_reached", (busy !== 1'b0 || sb.size() != 0) ? 1 : 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int hs2;
        int b0;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'd5;
        req_len   = 4'd0;
        wr_valid  = 1'b0;
        wr_data   = 8'd0;

        // Reset with a request pending: nothing accepted, outputs quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_ready", req_ready, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_rd_data", rd_data, 0);
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        tick();
        check("req_ready_after_release", req_ready, 1);
        check("busy_after_release", busy, 0);
        tick();
        check("busy_idle", busy, 0);

        // Fill the whole memory so every later read is predictable.
        for (int b = 0; b < 16; b++) begin
            write_burst(b * 16, 15, 16'($urandom) & 16'($urandom), 1'b1, 0);
        end

        // Write 1..4 at 100 with a stall before beat 3, then read back.
        write_burst(100, 3, 16'b0100, 1'b0, 1);
        read_burst(100, 3, hs);
        for (int i = 0; i < 5; i++) tick();
        check("req_ready_at_last_beat", req_ready, 0);
        tick();
        check("req_ready_after_last", req_ready, 1);
        check("busy_after_read", busy, 0);
        read_burst(104, 0, hs);
        wait_idle();

        // Address wrap.
        write_burst(254, 3, 16'b0, 1'b0, 'hA0);
        read_burst(0, 0, hs);
        wait_idle();
        read_burst(1, 0, hs);
        wait_idle();
        read_burst(254, 3, hs);
        wait_idle();

        // Single-beat read.
        b0 = beats_seen;
        read_burst(77, 0, hs);
        tick();
        tick();
        check("single_busy_on_beat", busy, 1);
        tick();
        check("single_busy_drop", busy, 0);
        check("single_beat_count", beats_seen - b0, 1);

        // Request held while a 16-beat read is in progress.
        b0 = beats_seen;
        read_burst(200, 15, hs);
        read_burst(30, 2, hs2);
        check("held_req_accept_cycle", hs2, hs + 2 + RD_LAT + 15);
        wait_idle();
        check("held_req_beats", beats_seen - b0, 19);

        // Reset two beats into an 8-beat read.
        b0 = beats_seen;
        read_burst(40, 7, hs);
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        sb.delete();
        check("beats_before_reset", beats_seen - b0, 2);
        tick();
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("req_ready_after_midrst", req_ready, 1);
        for (int i = 0; i < 8; i++) tick();
        check("no_beats_after_reset", beats_seen - b0, 2);
        read_burst(40, 7, hs);
        wait_idle();

        // Randomised mix of bursts.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                write_burst($urandom_range(0, 255), $urandom_range(0, 15),
                            16'($urandom) & 16'($urandom), 1'b1, 0);
            end else begin
                read_burst($urandom_range(0, 255), $urandom_range(0, 15), hs);
                if ($urandom_range(0, 1) == 1) wait_idle();
            end
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_burst.md
Name: data_mem_burst

Overview:
- Parametrised successor to the team's 8-bit data memory: single-port synchronous RAM behind a request/handshake front end.
- One accepted request moves a burst of 1..MAX_BURST consecutive words, either read or write.
- Read data path is pipelined with a configurable latency.
- Sits between the datapath/controller and storage; frees the controller from per-word address sequencing.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- RD_LAT, 1, read pipeline latency in cycles, legal range 1..4.
- MAX_BURST, 16, maximum beats per request; LEN_W = $clog2(MAX_BURST).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  beats minus 1.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  block accepts write beat.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat valid; no backpressure, consumer must take it.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  final beat of read burst, qualified by rd_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE; read pipeline flushed.
  - rd_valid=0, rd_last=0, rd_data=0, wr_ready=0, busy=0; req_ready=0 while rst_n=0, then 1 in the first cycle after release.
  - RAM contents are not cleared.
  - Reset beats a write strobe in the same cycle: no write occurs.
- States: IDLE, WR, RD, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch addr and len into the beat counter, then go to WR (req_write=1) or RD.
- WR:
  - wr_ready=1.
  - Each wr_valid & wr_ready: mem[addr] <= wr_data, addr++, count--.
  - wr_valid low inserts a stall; no write, no state change.
  - After the beat with count==0, go to IDLE; wr_ready=0 the next cycle.
- RD:
  - Issues one read per cycle, no stalls: addr++, count--.
  - The issue cycle with count==0 tags that beat last, then goes to DRAIN.
- DRAIN:
  - Waits until no beat is in flight in the RD_LAT pipeline, then goes to IDLE.
- Read latency:
  - Request handshake in cycle n: first rd_valid in cycle n+1+RD_LAT.
  - Beats are contiguous; rd_last is on beat len+1.
  - req_ready is 1 again in the cycle after rd_last.
- Write latency: data written in the handshake cycle is readable by any later read request (RAM is single port; no overlap is possible).
- Address arithmetic: increments modulo 2**ADDR_W, so 2**ADDR_W-1 wraps to 0. No error flag.
- Request while busy: req_ready=0. The requester holds its request, which is accepted exactly once when IDLE.
- req_len >= MAX_BURST cannot be encoded; LEN_W bounds it.
- Reset mid-burst:
  - Abort immediately; in-flight read beats are discarded.
  - rd_valid=0 from the next cycle.
  - Words already written persist.

Decomposition:
- Package data_mem_pkg:
  - state_t enum {IDLE, WR, RD, DRAIN}.
  - Default width constants DATA_W_DEF, ADDR_W_DEF.
  - Function computing LEN_W.
- Sub-module data_mem_array:
  - Single-port RAM with synchronous write.
  - Read path registered through RD_LAT stages.
  - Carries valid/last sidebands alongside the data.
  - Flushed by rst_n.
- Top level holds the FSM, address/beat counters and handshakes.

Test Plan (defaults except RD_LAT=2):
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, rd_valid=0, busy=0; req_ready=1 the cycle after release; no request accepted during reset.
- Write/read burst: write addr 100 len 3 with data 1,2,3,4, wr_valid low for one cycle before beat 3 -> 4 writes only; then read addr 100 len 3 accepted in cycle n -> rd_data 1,2,3,4 in cycles n+3..n+6, rd_last only in n+6, req_ready=1 in n+7.
- Wrap: write addr 254 len 3 with data 0xA0,0xA1,0xA2,0xA3 -> read addr 0 len 0 returns 0xA2; read addr 1 len 0 returns 0xA3; read addr 254 len 3 returns 0xA0..0xA3 in order.
- Single beat: read len 0 -> exactly one rd_valid, with rd_last=1 on it; busy drops the following cycle.
- Busy request: req_valid held from the cycle after a 16-beat read is accepted -> req_ready stays 0 until the cycle after rd_last; second request accepted exactly once.
- Reset mid-read: assert rst_n=0 after 2 beats of an 8-beat read -> rd_valid=0 the next cycle, no further beats, busy=0; a subsequent read returns the previously written data unchanged.
